// File: rtl/audio_chan_fetch.sv
// audio_chan_fetch: single-channel looping sample fetcher, splits 16-bit BRAM words into two signed bytes
// Ports: clk, reset_n_i (async active-low); chan_enable_i/chan_restart_i control; chan_start_i/chan_len_i
// loop window (latched at start/restart/wrap); chan_period_i clocks per sample minus 1; mem_rd_address_o/
// mem_rd_data_i registered-read BRAM port; sample_o/sample_valid_o sample stream; reload_o wrap pulse;
// chan_active_o high while not idle.
module audio_chan_fetch #(
  parameter int AWIDTH = 8,
  parameter int PWIDTH = 15
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              chan_enable_i,
  input  logic              chan_restart_i,
  input  logic [AWIDTH-1:0] chan_start_i,
  input  logic [AWIDTH-1:0] chan_len_i,
  input  logic [PWIDTH-1:0] chan_period_i,
  output logic [AWIDTH-1:0] mem_rd_address_o,
  input  logic [15:0]       mem_rd_data_i,
  output logic [7:0]        sample_o,
  output logic              sample_valid_o,
  output logic              reload_o,
  output logic              chan_active_o
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;
  state_t state, state_nxt;
  logic [AWIDTH-1:0] rem;
  logic [PWIDTH-1:0] pcnt, eff_period;
  logic [15:0] cur_word, nxt_word;
  logic byte_sel, restart;
  // pf[0]: prefetch address just issued; pf[1]: BRAM output holds the prefetched word
  logic [1:0] pf;
  assign eff_period = (chan_period_i < PWIDTH'(2)) ? PWIDTH'(2) : chan_period_i;
  assign restart = chan_enable_i && chan_restart_i && state != IDLE;
  assign chan_active_o = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = !chan_enable_i  ? IDLE  :
                restart         ? FETCH :
                state == IDLE   ? FETCH :
                state == FETCH  ? WAIT  : PLAY;
  end
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      mem_rd_address_o <= '0;
      rem <= '0;
      pcnt <= '0;
      cur_word <= '0;
      nxt_word <= '0;
      byte_sel <= 1'b0;
      pf <= '0;
      sample_o <= '0;
      sample_valid_o <= 1'b0;
      reload_o <= 1'b0;
    end else begin
      state <= state_nxt;
      sample_valid_o <= 1'b0;
      reload_o <= 1'b0;
      pf <= {pf[0], 1'b0};
      if (pf[1]) nxt_word <= mem_rd_data_i;
      if (!chan_enable_i) begin
        sample_o <= '0;
        pf <= '0;
      end else if (state == IDLE || restart) begin
        mem_rd_address_o <= chan_start_i;
        rem <= chan_len_i;
        pf <= '0;
      end else if (state == WAIT) begin
        cur_word <= mem_rd_data_i;
        sample_o <= mem_rd_data_i[15:8];
        sample_valid_o <= 1'b1;
        byte_sel <= 1'b0;
        pcnt <= eff_period;
      end else if (state == PLAY) begin
        if (pcnt != '0) begin
          pcnt <= pcnt - PWIDTH'(1);
        end else begin
          pcnt <= eff_period;
          sample_valid_o <= 1'b1;
          byte_sel <= ~byte_sel;
          if (!byte_sel) begin
            // low byte goes out now; fetch the next word while it plays
            sample_o <= cur_word[7:0];
            pf <= {pf[0], 1'b1};
            if (rem != '0) begin
              mem_rd_address_o <= mem_rd_address_o + AWIDTH'(1);
              rem <= rem - AWIDTH'(1);
            end else begin
              mem_rd_address_o <= chan_start_i;
              rem <= chan_len_i;
              reload_o <= 1'b1;
            end
          end else begin
            cur_word <= nxt_word;
            sample_o <= nxt_word[15:8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_chan_fetch.sv
// tb_audio_chan_fetch: scoreboard bench for audio_chan_fetch with a registered-read BRAM model
module tb_audio_chan_fetch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic rst_pulse = 1'b0;
  logic [7:0] start = '0;
  logic [7:0] len = '0;
  logic [14:0] period = '0;
  logic [7:0] addr, sample;
  logic [15:0] rd_data = '0;
  logic valid, reload, active;
  logic [15:0] mem [0:255];
  typedef struct {
    logic [7:0] s;
    logic r;
    int gap;
    bit from_mark;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mark_cyc = 0;
  int last_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[addr];
  audio_chan_fetch #(.AWIDTH(8), .PWIDTH(15)) dut (
    .clk(clk),
    .reset_n_i(reset_n),
    .chan_enable_i(en),
    .chan_restart_i(rst_pulse),
    .chan_start_i(start),
    .chan_len_i(len),
    .chan_period_i(period),
    .mem_rd_address_o(addr),
    .mem_rd_data_i(rd_data),
    .sample_o(sample),
    .sample_valid_o(valid),
    .reload_o(reload),
    .chan_active_o(active)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] s, input logic r, input int gap, input bit m);
    exp_t e;
    e.s = s;
    e.r = r;
    e.gap = gap;
    e.from_mark = m;
    q.push_back(e);
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %02h expected none", sample);
        end else begin
          e = q.pop_front();
          chk("sample", sample, e.s);
          chk("reload_with_sample", reload, e.r);
          chk("sample_gap", cyc - (e.from_mark ? mark_cyc : last_cyc), e.gap);
        end
        last_cyc = cyc;
      end else if (reload) begin
        checks++;
        errors++;
        $display("FAIL stray_reload: got reload=1 without sample expected 0");
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go();
    tick();
    en = 1'b1;
    mark_cyc = cyc;
  endtask
  task automatic stop();
    tick();
    en = 1'b0;
    tick();
    chk("idle_sample", sample, 8'h00);
    chk("idle_active", active, 1'b0);
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d samples pending expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic wait_sample(input logic [7:0] v, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid && sample == v) && n < budget);
    checks++;
    if (!(valid && sample == v)) begin
      errors++;
      $display("FAIL wait_sample: got timeout expected sample %02h", v);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h5678;
    mem[8'h20] = 16'hA0B0;
    mem[8'hFF] = 16'h0102;
    mem[8'h00] = 16'h0304;
    fork
      monitor();
    join_none
    #12;
    chk("rst_sample", sample, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_reload", reload, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_addr", addr, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_active", active, 1'b0);
    start = 8'h10;
    len = 8'd1;
    period = 15'd3;
    go();
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    push(8'h56, 1'b0, 4, 1'b0);
    push(8'h78, 1'b1, 4, 1'b0);
    push(8'h12, 1'b0, 4, 1'b0);
    push(8'h34, 1'b0, 4, 1'b0);
    push(8'h56, 1'b0, 4, 1'b0);
    push(8'h78, 1'b1, 4, 1'b0);
    tick();
    chk("start_addr", addr, 8'h10);
    chk("start_active", active, 1'b1);
    drain(60);
    stop();
    for (int p = 0; p < 2; p++) begin
      period = 15'(p);
      go();
      push(8'h12, 1'b0, 4, 1'b1);
      push(8'h34, 1'b0, 3, 1'b0);
      push(8'h56, 1'b0, 3, 1'b0);
      push(8'h78, 1'b1, 3, 1'b0);
      push(8'h12, 1'b0, 3, 1'b0);
      push(8'h34, 1'b0, 3, 1'b0);
      drain(40);
      stop();
    end
    period = 15'd3;
    go();
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    push(8'h56, 1'b0, 4, 1'b0);
    push(8'h78, 1'b1, 4, 1'b0);
    push(8'hA0, 1'b0, 4, 1'b0);
    push(8'hB0, 1'b1, 4, 1'b0);
    push(8'hA0, 1'b0, 4, 1'b0);
    push(8'hB0, 1'b1, 4, 1'b0);
    repeat (6) tick();
    start = 8'h20;
    len = 8'd0;
    drain(80);
    stop();
    start = 8'hFF;
    len = 8'd1;
    period = 15'd2;
    go();
    push(8'h01, 1'b0, 4, 1'b1);
    push(8'h02, 1'b0, 3, 1'b0);
    push(8'h03, 1'b0, 3, 1'b0);
    push(8'h04, 1'b1, 3, 1'b0);
    push(8'h01, 1'b0, 3, 1'b0);
    tick();
    chk("wrap_addr_ff", addr, 8'hFF);
    repeat (5) tick();
    chk("wrap_addr_00", addr, 8'h00);
    repeat (6) tick();
    chk("wrap_addr_back", addr, 8'hFF);
    drain(40);
    stop();
    start = 8'h10;
    len = 8'd1;
    period = 15'd3;
    go();
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    wait_sample(8'h34, 20);
    chk("pre_restart_addr", addr, 8'h11);
    tick();
    rst_pulse = 1'b1;
    mark_cyc = cyc;
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    push(8'h56, 1'b0, 4, 1'b0);
    tick();
    rst_pulse = 1'b0;
    chk("restart_addr", addr, 8'h10);
    chk("restart_active", active, 1'b1);
    chk("restart_valid", valid, 1'b0);
    wait_sample(8'h56, 30);
    repeat (3) tick();
    rst_pulse = 1'b1;
    mark_cyc = cyc;
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    tick();
    rst_pulse = 1'b0;
    chk("restart_wrap_reload", reload, 1'b0);
    chk("restart_wrap_valid", valid, 1'b0);
    chk("restart_wrap_addr", addr, 8'h10);
    drain(40);
    stop();
    go();
    push(8'h12, 1'b0, 4, 1'b1);
    push(8'h34, 1'b0, 4, 1'b0);
    wait_sample(8'h34, 20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sample", sample, 8'h00);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_addr", addr, 8'h00);
    chk("async_rst_active", active, 1'b0);
    chk("async_rst_reload", reload, 1'b0);
    en = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("final_active", active, 1'b0);
    chk("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_chan_fetch.md
Name: audio_chan_fetch

Overview:
- Single audio channel playback engine; directly downstream of the 16-bit audio sample BRAM and drives its read port.
- Fetches sample words from a start address over a programmed length and splits each word into two signed 8-bit samples, high byte first.
- Presents samples at a programmed period and loops forever.
- At each loop wrap, picks up new start/length values, enabling double-buffered waveform queuing, and pulses reload_o to the interrupt logic.

Parameters:
AWIDTH, 8, sample memory word address width (length counter uses same width)
PWIDTH, 15, period counter width

Ports:
clk  input  1  system clock
reset_n_i  input  1  asynchronous active-low reset
chan_enable_i  input  1  level; 1 = channel plays, 0 = channel idle
chan_restart_i  input  1  one-clock pulse; abort and restart from chan_start_i
chan_start_i  input  AWIDTH  loop start word address, sampled at start/restart/wrap only
chan_len_i  input  AWIDTH  loop length in words minus 1, sampled at start/restart/wrap only
chan_period_i  input  PWIDTH  clocks per sample minus 1; values below 2 are treated as 2
mem_rd_address_o  output  AWIDTH  registered read address to sample BRAM
mem_rd_data_i  input  16  BRAM read data, registered read: valid one clock after address is sampled
sample_o  output  8  current signed sample
sample_valid_o  output  1  one-clock pulse when sample_o takes a new value
reload_o  output  1  one-clock pulse when the loop wraps and new start/len are latched
chan_active_o  output  1  1 while not IDLE

Behaviour:
- Reset (async, immediate, no clock required):
  - All outputs 0; state IDLE.
  - Word buffers, counters and byte select all 0.
- Memory timing:
  - mem_rd_address_o is loaded at edge E0; BRAM samples it at E1; block captures mem_rd_data_i at E2.
  - Fetch latency is 2 edges.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - Entered on reset, or on any edge where chan_enable_i=0 from any state.
  - On entry/while in IDLE: sample_o<=0; no valid/reload pulses.
  - chan_enable_i=1 -> FETCH, with addr<=chan_start_i, rem<=chan_len_i.
- FETCH: unconditional -> WAIT (BRAM latching).
- WAIT -> PLAY, and in the same edge:
  - cur_word<=mem_rd_data_i; sample_o<=mem_rd_data_i[15:8]; sample_valid_o=1.
  - byte_sel<=0; pcnt<=eff_period, where eff_period=max(chan_period_i,2).
- PLAY: pcnt decrements each clock. At pcnt==0:
  - byte_sel==0:
    - sample_o<=cur_word[7:0]; byte_sel<=1; valid pulse; pcnt<=eff_period.
    - Issue prefetch (addressing rule below); nxt_word captured 2 edges later.
  - byte_sel==1:
    - cur_word<=nxt_word; sample_o<=nxt_word[15:8]; byte_sel<=0; valid pulse; pcnt<=eff_period.
- Addressing rule at prefetch:
  - rem!=0: addr<=addr+1 (modulo 2^AWIDTH, wraps 0xFF->0x00); rem<=rem-1.
  - rem==0 (loop wrap): addr<=chan_start_i; rem<=chan_len_i; reload_o=1 for that clock.
- Sample spacing:
  - Samples are spaced exactly eff_period+1 clocks with no gaps, including across wraps.
  - The minimum period of 2 guarantees nxt_word is captured one clock before use.
- chan_period_i changes take effect at the next pcnt reload only.
- chan_start_i/chan_len_i changes mid-loop have no effect until the next wrap; the current loop always completes.
- chan_restart_i=1 with chan_enable_i=1, any non-IDLE state:
  - -> FETCH; addr<=chan_start_i; rem<=chan_len_i; sample_o holds.
  - Restart overrides a coincident wrap or sample step: no reload_o, no sample_valid_o that clock.
- chan_restart_i in IDLE is ignored; enable alone starts.
- Disable has priority over restart.
- len=0 (single word): every prefetch is a wrap; reload_o pulses once per word.
- chan_active_o=1 in FETCH, WAIT and PLAY.

Test Plan:
- Basic loop: mem[0x10]=0x1234, mem[0x11]=0x5678, start=0x10, len=1, period=3; assert enable.
  - First sample_valid_o 3 edges after enable edge.
  - sample_o sequence 0x12,0x34,0x56,0x78,0x12,... every 4 clocks.
  - reload_o pulses in the same clock sample_o becomes 0x78.
- Period clamp: period=0 and period=1 -> samples spaced exactly 3 clocks, correct byte order, no stale nxt_word.
- Queued reload:
  - Change start to 0x20 (mem[0x20]=0xA0B0) and len to 0 mid-loop.
  - Old loop completes through 0x78, then 0xA0,0xB0 repeat.
  - reload_o every word thereafter.
- Address wrap: start=0xFF, len=1, mem[0xFF]=0x0102, mem[0x00]=0x0304 -> mem_rd_address_o 0xFF,0x00,0xFF; samples 0x01,0x02,0x03,0x04.
- Restart:
  - Pulse chan_restart_i mid-PLAY -> FETCH next clock, address=chan_start_i, next valid 3 edges later.
  - Restart coincident with wrap -> reload_o stays 0.
- Reset/disable:
  - reset_n_i low mid-PLAY between clock edges -> all outputs 0 immediately.
  - chan_enable_i low -> IDLE next edge, sample_o=0, chan_active_o=0.
